// File: rtl/if_stage_fq.sv
// Instruction fetch stage: addr_ok/data_ok memory port, up to MAX_OUT fetches in flight,
// and an FQ_DEPTH-entry fetch queue feeding decode. Redirects squash in-flight responses.
module if_stage_fq #(
    parameter logic [31:0] RESET_PC  = 32'h1c000000,
    parameter int unsigned FQ_DEPTH  = 4,
    parameter int unsigned MAX_OUT   = 2,
    parameter int unsigned BP_INFO_W = 36
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           flush_valid,
    input  logic [31:0]                    flush_pc,
    input  logic                           br_valid,
    input  logic [31:0]                    br_target,
    output logic [31:0]                    bp_pc_o,
    input  logic                           bp_taken,
    input  logic [31:0]                    bp_target,
    input  logic [BP_INFO_W-1:0]           bp_info,
    output logic                           inst_req,
    output logic [31:0]                    inst_addr,
    input  logic                           inst_addr_ok,
    input  logic                           inst_data_ok,
    input  logic [31:0]                    inst_rdata,
    output logic                           fs_to_ds_valid,
    input  logic                           ds_allowin,
    output logic [BP_INFO_W+63:0]          fs_to_ds_bus,
    output logic [$clog2(FQ_DEPTH+1)-1:0]  fq_count
);

    localparam int unsigned CW  = $clog2(FQ_DEPTH + 1);
    localparam int unsigned OW  = $clog2(MAX_OUT + 1);
    localparam int unsigned FPW = $clog2(FQ_DEPTH);
    localparam int unsigned MPW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned BW  = BP_INFO_W + 64;

    logic [31:0]          fetch_pc;
    logic [OW-1:0]        inflight;
    logic [OW-1:0]        discard;

    logic [31:0]          meta_pc   [MAX_OUT];
    logic [BP_INFO_W-1:0] meta_info [MAX_OUT];
    logic [MPW-1:0]       meta_wr;
    logic [MPW-1:0]       meta_rd;

    logic [BW-1:0]        fq_mem [FQ_DEPTH];
    logic [FPW-1:0]       fq_wr;
    logic [FPW-1:0]       fq_rd;

    logic                 redirect;
    logic [31:0]          redirect_pc;
    logic                 accept;
    logic                 fq_push;
    logic                 fq_pop;

    function automatic logic [MPW-1:0] meta_next(input logic [MPW-1:0] p);
        return (32'(p) == MAX_OUT - 1) ? '0 : p + MPW'(1);
    endfunction

    always_comb begin
        redirect       = flush_valid || br_valid;
        redirect_pc    = flush_valid ? flush_pc : br_target;
        // Credits count responses still in flight (even squashed ones) so every
        // accepted fetch is guaranteed an FQ slot when its data returns.
        inst_req       = resetn && !redirect
                         && (32'(inflight) < MAX_OUT)
                         && (32'(inflight) + 32'(fq_count) < FQ_DEPTH);
        accept         = inst_req && inst_addr_ok;
        fq_push        = inst_data_ok && !redirect && (discard == '0);
        fs_to_ds_valid = (fq_count != '0);
        fq_pop         = fs_to_ds_valid && ds_allowin && !redirect;
        inst_addr      = fetch_pc;
        bp_pc_o        = fetch_pc;
        fs_to_ds_bus   = fq_mem[fq_rd];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            meta_wr  <= '0;
            meta_rd  <= '0;
            fq_wr    <= '0;
            fq_rd    <= '0;
            fq_count <= '0;
        end else begin
            if (redirect)
                fetch_pc <= redirect_pc;
            else if (accept)
                fetch_pc <= bp_taken ? bp_target : fetch_pc + 32'd4;

            inflight <= inflight + OW'(accept) - OW'(inst_data_ok);

            // No accept can happen in a redirect cycle, so everything left in flight is stale.
            if (redirect)
                discard <= inflight - OW'(inst_data_ok);
            else if (inst_data_ok && discard != '0)
                discard <= discard - OW'(1);

            if (accept)
                meta_wr <= meta_next(meta_wr);
            if (inst_data_ok)
                meta_rd <= meta_next(meta_rd);

            if (redirect) begin
                fq_wr    <= '0;
                fq_rd    <= '0;
                fq_count <= '0;
            end else begin
                if (fq_push)
                    fq_wr <= fq_wr + FPW'(1);
                if (fq_pop)
                    fq_rd <= fq_rd + FPW'(1);
                fq_count <= fq_count + CW'(fq_push) - CW'(fq_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            meta_pc[meta_wr]   <= fetch_pc;
            meta_info[meta_wr] <= bp_info;
        end
        if (fq_push)
            fq_mem[fq_wr] <= {meta_info[meta_rd], inst_rdata, meta_pc[meta_rd]};
    end

endmodule

// File: tb/tb_if_stage_fq.sv
// Randomized bench for if_stage_fq: a request-level model predicts fetch addresses,
// request gating and the instruction stream that decode must observe.
module tb_if_stage_fq;

    localparam logic [31:0] RESET_PC  = 32'h1c000000;
    localparam int          FQ_DEPTH  = 4;
    localparam int          MAX_OUT   = 2;
    localparam int          BP_INFO_W = 36;
    localparam int          BW        = BP_INFO_W + 64;

    logic                          clk = 1'b0;
    logic                          resetn;
    logic                          flush_valid, br_valid;
    logic [31:0]                   flush_pc, br_target;
    logic [31:0]                   bp_pc_o;
    logic                          bp_taken;
    logic [31:0]                   bp_target;
    logic [BP_INFO_W-1:0]          bp_info;
    logic                          inst_req;
    logic [31:0]                   inst_addr;
    logic                          inst_addr_ok, inst_data_ok;
    logic [31:0]                   inst_rdata;
    logic                          fs_to_ds_valid;
    logic                          ds_allowin;
    logic [BW-1:0]                 fs_to_ds_bus;
    logic [$clog2(FQ_DEPTH+1)-1:0] fq_count;

    if_stage_fq #(
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (FQ_DEPTH),
        .MAX_OUT  (MAX_OUT),
        .BP_INFO_W(BP_INFO_W)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .flush_valid   (flush_valid),
        .flush_pc      (flush_pc),
        .br_valid      (br_valid),
        .br_target     (br_target),
        .bp_pc_o       (bp_pc_o),
        .bp_taken      (bp_taken),
        .bp_target     (bp_target),
        .bp_info       (bp_info),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata),
        .fs_to_ds_valid(fs_to_ds_valid),
        .ds_allowin    (ds_allowin),
        .fs_to_ds_bus  (fs_to_ds_bus),
        .fq_count      (fq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]          addr;
        logic [BP_INFO_W-1:0] info;
        bit                   stale;
    } req_t;

    req_t          outq[$];
    logic [BW-1:0] expq[$];
    logic [31:0]   exp_pc;
    bit            in_reset;
    int            n_cmp  = 0;
    int            n_fail = 0;
    int            n_deliv = 0;
    logic [31:0]   last_pc;

    int unsigned   p_addr_ok, p_data_ok, p_allow, p_taken, p_redir;
    logic [31:0]   taken_pc, taken_tgt;
    bit            force_flush, force_br;
    logic [31:0]   force_flush_pc, force_br_pc;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h5a5a0f0f;
    endfunction

    function automatic logic [31:0] rand_pc();
        return {16'h1c00, 14'($urandom), 2'b00};
    endfunction

    task automatic model_reset();
        outq.delete();
        expq.delete();
        exp_pc = RESET_PC;
    endtask

    // Model the cycle whose inputs are now stable (runs before the next rising edge).
    task automatic model_step();
        bit   redir;
        bit   req_exp;
        req_t r;
        redir   = flush_valid || br_valid;
        req_exp = !redir && (outq.size() < MAX_OUT) && (outq.size() + expq.size() < FQ_DEPTH);
        chk("inst_req", 128'(inst_req), 128'(req_exp));
        chk("inst_addr", 128'(inst_addr), 128'(exp_pc));
        chk("bp_pc_o", 128'(bp_pc_o), 128'(exp_pc));
        chk("fq_count", 128'(fq_count), 128'(expq.size()));
        if (inst_data_ok && outq.size() > 0) begin
            r = outq.pop_front();
            if (!r.stale && !redir)
                expq.push_back({r.info, mem_data(r.addr), r.addr});
        end
        if (req_exp && inst_addr_ok) begin
            outq.push_back('{addr: exp_pc, info: bp_info, stale: 1'b0});
            exp_pc = bp_taken ? bp_target : exp_pc + 32'd4;
        end
        if (redir) begin
            foreach (outq[i]) outq[i].stale = 1'b1;
            expq.delete();
            exp_pc = flush_valid ? flush_pc : br_target;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        inst_addr_ok = ($urandom_range(99) < p_addr_ok);
        inst_data_ok = (outq.size() > 0) && ($urandom_range(99) < p_data_ok);
        inst_rdata   = inst_data_ok ? mem_data(outq[0].addr) : $urandom;
        ds_allowin   = ($urandom_range(99) < p_allow);
        bp_info      = BP_INFO_W'({$urandom, $urandom});
        flush_valid  = force_flush || ($urandom_range(199) < p_redir);
        flush_pc     = force_flush ? force_flush_pc : rand_pc();
        br_valid     = force_br || ($urandom_range(199) < p_redir);
        br_target    = force_br ? force_br_pc : rand_pc();
        #1;
        if (bp_pc_o == taken_pc) begin
            bp_taken  = 1'b1;
            bp_target = taken_tgt;
        end else begin
            bp_taken  = ($urandom_range(99) < p_taken);
            bp_target = rand_pc();
        end
        #1;
        model_step();
    endtask

    task automatic quiet_inputs();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        flush_valid  = 1'b0;
        br_valid     = 1'b0;
        ds_allowin   = 1'b0;
        bp_taken     = 1'b0;
    endtask

    task automatic set_knobs(input int unsigned a, d, w, t, r);
        p_addr_ok = a; p_data_ok = d; p_allow = w; p_taken = t; p_redir = r;
    endtask

    task automatic fill_two_inflight();
        set_knobs(100, 0, 100, 0, 0);
        for (int i = 0; i < 20 && outq.size() < 2; i++) cycle();
        chk("two_inflight_reached", 128'(outq.size()), 128'(2));
    endtask

    task automatic expect_first_pc(input string name, input logic [31:0] pc);
        int d0;
        d0 = n_deliv;
        for (int i = 0; i < 40 && n_deliv == d0; i++) cycle();
        chk(name, 128'(last_pc), 128'(pc));
    endtask

    // Monitor: pops the scoreboard whenever decode takes the FQ head.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!in_reset && fs_to_ds_valid && ds_allowin && !(flush_valid || br_valid)) begin
                n_deliv++;
                last_pc = fs_to_ds_bus[31:0];
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output actual=%h expected=none", fs_to_ds_bus);
                end else begin
                    chk("ds_bus", 128'(fs_to_ds_bus), 128'(expq.pop_front()));
                end
            end
        end
    end

    initial begin
        int d0;
        taken_pc    = 32'hffffffff;
        taken_tgt   = '0;
        force_flush = 1'b0;
        force_br    = 1'b0;
        flush_pc    = '0;
        br_target   = '0;
        bp_target   = '0;
        bp_info     = '0;
        inst_rdata  = '0;
        quiet_inputs();
        in_reset = 1'b1;
        resetn   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #2;
        chk("rst_inst_req", 128'(inst_req), 128'(0));
        chk("rst_valid", 128'(fs_to_ds_valid), 128'(0));
        chk("rst_fq_count", 128'(fq_count), 128'(0));
        chk("rst_inst_addr", 128'(inst_addr), 128'(RESET_PC));
        resetn   = 1'b1;
        in_reset = 1'b0;

        // Always-ready memory and decode, with a taken prediction at 1c000008.
        taken_pc  = 32'h1c000008;
        taken_tgt = 32'h1c000100;
        set_knobs(100, 100, 100, 0, 0);
        repeat (10) cycle();
        taken_pc = 32'hffffffff;
        d0 = n_deliv;
        repeat (20) cycle();
        chk("steady_throughput", 128'(n_deliv - d0), 128'(20));

        // Decode stall: queue must saturate at FQ_DEPTH with requests held off.
        set_knobs(100, 100, 0, 0, 0);
        repeat (10) cycle();
        chk("fq_saturated", 128'(fq_count), 128'(FQ_DEPTH));
        chk("req_held_when_full", 128'(inst_req), 128'(0));
        set_knobs(100, 100, 100, 0, 0);
        repeat (10) cycle();

        // Mispredict with two requests in flight.
        fill_two_inflight();
        force_br    = 1'b1;
        force_br_pc = 32'h1c000200;
        cycle();
        force_br = 1'b0;
        set_knobs(100, 100, 100, 0, 0);
        expect_first_pc("first_pc_after_br", 32'h1c000200);

        // Flush and mispredict together: flush wins.
        fill_two_inflight();
        force_flush    = 1'b1;
        force_flush_pc = 32'h1c008000;
        force_br       = 1'b1;
        force_br_pc    = 32'h1c000200;
        cycle();
        force_flush = 1'b0;
        force_br    = 1'b0;
        set_knobs(100, 100, 100, 0, 0);
        expect_first_pc("first_pc_after_flush", 32'h1c008000);

        // Randomized traffic.
        set_knobs(70, 60, 70, 15, 6);
        repeat (1500) cycle();
        set_knobs(0, 100, 100, 0, 0);
        repeat (20) cycle();
        chk("drain_fq_empty", 128'(fq_count), 128'(0));
        chk("drain_scoreboard_empty", 128'(expq.size()), 128'(0));

        // Asynchronous reset mid-stream with two fetches outstanding.
        set_knobs(100, 100, 100, 0, 0);
        repeat (5) cycle();
        fill_two_inflight();
        @(negedge clk);
        #1;
        resetn   = 1'b0;
        in_reset = 1'b1;
        quiet_inputs();
        #1;
        chk("mid_rst_inst_req", 128'(inst_req), 128'(0));
        chk("mid_rst_valid", 128'(fs_to_ds_valid), 128'(0));
        chk("mid_rst_fq_count", 128'(fq_count), 128'(0));
        chk("mid_rst_inst_addr", 128'(inst_addr), 128'(RESET_PC));
        model_reset();
        repeat (2) @(negedge clk);
        resetn   = 1'b1;
        in_reset = 1'b0;
        set_knobs(100, 100, 100, 0, 0);
        expect_first_pc("first_pc_after_reset", RESET_PC);
        repeat (10) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage_fq.md
Name: if_stage_fq

Overview:
- Next-generation instruction fetch stage with a request/response (addr_ok/data_ok) instruction memory interface.
- Supports multiple outstanding fetches and a parametrised instruction fetch queue (FQ) that decouples fetch from decode.
- Takes next-PC predictions from the branch predictor and redirects on flush or branch mispredict, discarding stale in-flight responses.
- Sits between the PC/branch-predictor logic and the decode stage.

Parameters:
- RESET_PC, 32'h1c000000, address of the first fetch after reset.
- FQ_DEPTH, 4, FQ entries; power of two, >=2.
- MAX_OUT, 2, maximum outstanding memory requests; power of two, >=1.
- BP_INFO_W, 36, width of the opaque predictor metadata carried with each instruction.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- flush_valid  in  1  exception/ertn redirect.
- flush_pc  in  32  flush target.
- br_valid  in  1  execute-stage mispredict redirect.
- br_target  in  32  corrected PC.
- bp_pc_o  out  32  PC of the request currently presented (equals inst_addr).
- bp_taken  in  1  predictor says taken for bp_pc_o (combinational, same cycle).
- bp_target  in  32  predicted target.
- bp_info  in  BP_INFO_W  metadata for bp_pc_o, passed through to decode.
- inst_req  out  1  fetch request.
- inst_addr  out  32  fetch address.
- inst_addr_ok  in  1  request accepted this cycle.
- inst_data_ok  in  1  response valid (in request order).
- inst_rdata  in  32  response data.
- fs_to_ds_valid  out  1  FQ head valid.
- ds_allowin  in  1  decode accepts head.
- fs_to_ds_bus  out  BP_INFO_W+64  {bp_info, inst, pc}.
- fq_count  out  $clog2(FQ_DEPTH+1)  FQ occupancy.

Behaviour:
- Reset (resetn low, asynchronous): all registers clear immediately.
  - fetch_pc=RESET_PC; inflight=0; discard=0; FQ and metadata FIFO empty.
  - Outputs: inst_req=0, fs_to_ds_valid=0, fq_count=0.
  - fetch_pc drives inst_addr and bp_pc_o (RESET_PC while reset asserted).
  - The first inst_req is asserted in the first cycle after resetn deasserts.
- Request rule: inst_req = !redirect && (inflight < MAX_OUT) && (inflight + fq_count < FQ_DEPTH). Counts are registered values, so every accepted response has a guaranteed FQ slot. redirect = flush_valid || br_valid.
- Accept (inst_req && inst_addr_ok):
  - push {fetch_pc, bp_info} into the metadata FIFO (depth MAX_OUT);
  - inflight += 1;
  - fetch_pc <= bp_taken ? bp_target : fetch_pc+4 (32-bit wrap).
- inst_req may drop without acceptance (redirect); the memory bridge tolerates withdrawal.
- Response (inst_data_ok):
  - pop the metadata FIFO; inflight -= 1;
  - if discard>0: drop the data and discard -= 1;
  - otherwise push {meta.bp_info, inst_rdata, meta.pc} into the FQ.
  - Accept and response in the same cycle: inflight unchanged.
- Decode handshake: fs_to_ds_valid = FQ non-empty; the head is popped when fs_to_ds_valid && ds_allowin. fs_to_ds_bus is stable while valid and not popped. Zero-latency bypass is not provided: data lands in the FQ one cycle after data_ok.
- FQ push and pop in the same cycle: count unchanged, legal at any occupancy including full. Overflow is impossible by the credit rule; the bench asserts this.
- Redirect (flush_valid has priority over br_valid):
  - fetch_pc <= flush_pc or br_target; FQ cleared; the same-cycle ds pop is ignored.
  - discard <= inflight − (data_ok ? 1 : 0) + (discard-adjusted): all requests still outstanding after this cycle are discarded. Any response arriving in the redirect cycle is dropped.
  - inst_req=0 in the redirect cycle; normal fetch resumes from the new PC the next cycle.
- Back-to-back redirects: each recomputes discard from current inflight. The latest target wins.
- Empty fetch: if FQ is empty and decode stalls, there is no effect.
- Full FQ: inst_req stays 0 until a pop frees credit.

Test Plan:
- Reset release, always-ready memory (addr_ok=1, data_ok one cycle later), ds_allowin=1 -> decode sees pc 1c000000, 1c000004, 1c000008… in order; one instruction per cycle at steady state.
- ds_allowin=0 for 10 cycles -> fq_count saturates at 4; inst_req=0 while inflight+count=4; no data lost; release yields pc sequence continuous.
- bp_taken=1 with bp_target=1c000100 on pc 1c000008 -> next fetched pc 1c000100; the bus for 1c000008 carries the matching bp_info.
- Two requests in flight (MAX_OUT=2), br_valid with br_target=1c000200 -> FQ empties that cycle; the next two data_ok are dropped; the first delivered pc is 1c000200.
- flush_valid (flush_pc=1c008000) and br_valid asserted in the same cycle -> fetch resumes at 1c008000.
- resetn pulsed low mid-stream with 2 in flight -> outputs clear immediately; after release, fetch restarts at RESET_PC with fq_count=0.
